// File: rtl/spi_request_arbiter_if.sv
// Requester/engine signal bundle for the SPI request arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold REQ_I until their ACK_O pulse; the engine is handshaked via start/done levels.
interface spi_request_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    REQ_I;
    logic [2*NREQ-1:0]  SEL_I;
    logic [32*NREQ-1:0] DATA_I;
    logic [NREQ-1:0]    ACK_O;
    logic               ERR_O;
    logic [31:0]        RDATA_O;
    logic [NREQ-1:0]    GRANT_O;
    logic               BUSY_O;
    logic               SPI_STAR_O;
    logic [1:0]         SPI_SEL_O;
    logic [31:0]        SPI_DATA_O;
    logic               SPI_DONE_I;
    logic [31:0]        SPI_RDATA_I;

    // Arbiter side.
    modport master (
        input  REQ_I, SEL_I, DATA_I, SPI_DONE_I, SPI_RDATA_I,
        output ACK_O, ERR_O, RDATA_O, GRANT_O, BUSY_O, SPI_STAR_O, SPI_SEL_O, SPI_DATA_O
    );

    // Requesters plus engine side.
    modport slave (
        output REQ_I, SEL_I, DATA_I, SPI_DONE_I, SPI_RDATA_I,
        input  ACK_O, ERR_O, RDATA_O, GRANT_O, BUSY_O, SPI_STAR_O, SPI_SEL_O, SPI_DATA_O
    );
endinterface

// File: rtl/spi_request_arbiter.sv
// Round-robin sharing of one SPI engine among NREQ requesters, with per-phase watchdog.
// Latency: request to grant/start 1 cycle; done falling to ACK_O 1 cycle; at least one idle cycle between transfers.
// Backpressure: one transfer outstanding; other requesters wait holding REQ_I until their ACK_O.
module spi_request_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                  BOARD_CLOCK,
    input  logic                  RST,
    spi_request_arbiter_if.master bus
);
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [15:0]     wd_q, wd_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            star_q, star_d;
    logic [1:0]      sel_q, sel_d;
    logic [31:0]     data_q, data_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic [NREQ-1:0] grant_pick;
    logic [1:0]      sel_pick;
    logic [31:0]     data_pick;
    logic            wd_expired;

    assign wd_expired = (wd_q == 16'(TIMEOUT - 1));

    // Winner search starting just after the last owner, then mux its select/command.
    always_comb begin
        found      = 1'b0;
        win        = last_q;
        cand       = last_q;
        grant_pick = '0;
        sel_pick   = '0;
        data_pick  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(last_q) + off) % NREQ);
            if (!found && bus.REQ_I[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                grant_pick[i] = 1'b1;
                sel_pick      = bus.SEL_I[2*i +: 2];
                data_pick     = bus.DATA_I[32*i +: 32];
            end
        end
    end

    // Handshake FSM next-state; every output is a register loaded from here.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        ack_d   = '0;
        err_d   = err_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        star_d  = star_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = grant_pick;
                    last_d  = win;
                    sel_d   = sel_pick;
                    data_d  = data_pick;
                    wd_d    = '0;
                    star_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (bus.SPI_DONE_I) begin
                    rdata_d = bus.SPI_RDATA_I;
                    star_d  = 1'b0;
                    wd_d    = '0;
                    state_d = ST_RELEASE;
                end else if (wd_expired) begin
                    star_d  = 1'b0;
                    err_d   = 1'b1;
                    ack_d   = grant_q;
                    state_d = ST_ACK;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (!bus.SPI_DONE_I) begin
                    err_d   = 1'b0;
                    ack_d   = grant_q;
                    state_d = ST_ACK;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    ack_d   = grant_q;
                    state_d = ST_ACK;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; an aborted transfer is never acknowledged.
    always_ff @(posedge BOARD_CLOCK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(NREQ - 1);
            wd_q    <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            star_q  <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            star_q  <= star_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign bus.ACK_O      = ack_q;
    assign bus.ERR_O      = err_q;
    assign bus.RDATA_O    = rdata_q;
    assign bus.GRANT_O    = grant_q;
    assign bus.BUSY_O     = busy_q;
    assign bus.SPI_STAR_O = star_q;
    assign bus.SPI_SEL_O  = sel_q;
    assign bus.SPI_DATA_O = data_q;
endmodule

// File: tb/tb_spi_request_arbiter.sv
// Scoreboard bench for spi_request_arbiter with a level-based SPI engine model.
// Latency: expectations checked at grant and at each ACK_O pulse.
// Backpressure: requesters hold REQ_I until ACK_O, optionally re-requesting continuously.
module tb_spi_request_arbiter;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;

    typedef struct {
        int          idx;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    logic        eng_mute  = 1'b0;
    logic [31:0] eng_rdata = 32'h0;
    int          hold_left = 0;
    int          star_cycles = 0;
    logic [NREQ-1:0] prev_grant = '0;

    spi_request_arbiter_if #(.NREQ(NREQ)) bus ();

    spi_request_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .BOARD_CLOCK (clk),
        .RST         (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic request(input int i, input logic [1:0] sel, input logic [31:0] data,
                           input logic [31:0] rdata, input logic err);
        exp_t e;
        bus.SEL_I[2*i +: 2]   = sel;
        bus.DATA_I[32*i +: 32] = data;
        bus.REQ_I[i]          = 1'b1;
        e.idx = i; e.sel = sel; e.data = data; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (bus.GRANT_O == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(bus.GRANT_O != '0), 64'd1);
    endtask

    task automatic wait_star_low(input string tag);
        int n = 0;
        while (bus.SPI_STAR_O && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(bus.SPI_STAR_O), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   64'(bus.ACK_O),      64'd0);
        check({tag, "_err"},   64'(bus.ERR_O),      64'd0);
        check({tag, "_rdata"}, 64'(bus.RDATA_O),    64'd0);
        check({tag, "_grant"}, 64'(bus.GRANT_O),    64'd0);
        check({tag, "_busy"},  64'(bus.BUSY_O),     64'd0);
        check({tag, "_star"},  64'(bus.SPI_STAR_O), 64'd0);
        check({tag, "_sel"},   64'(bus.SPI_SEL_O),  64'd0);
        check({tag, "_data"},  64'(bus.SPI_DATA_O), 64'd0);
    endtask

    // Engine model: done rises after 40 cycles of start, falls 10 cycles after start drops.
    initial begin
        int cnt = 0;
        bus.SPI_DONE_I  = 1'b0;
        bus.SPI_RDATA_I = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.SPI_RDATA_I = eng_rdata;
            if (rst) begin
                bus.SPI_DONE_I = 1'b0;
                cnt = 0;
            end else if (!bus.SPI_DONE_I) begin
                if (bus.SPI_STAR_O) begin
                    cnt++;
                    if (cnt >= 40 && !eng_mute) begin
                        bus.SPI_DONE_I = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                if (!bus.SPI_STAR_O) begin
                    cnt++;
                    if (cnt >= 10) begin
                        bus.SPI_DONE_I = 1'b0;
                        cnt = 0;
                    end
                end
            end
        end
    end

    // Monitor: checks grant against the scoreboard head, pops and compares on ACK_O.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_grant == '0 && bus.GRANT_O != '0) begin
                    star_cycles = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_grant", 64'(bus.GRANT_O), 64'd0);
                    end else begin
                        e = sb[0];
                        check("grant_onehot", 64'(bus.GRANT_O), 64'(1 << e.idx));
                        check("grant_sel",    64'(bus.SPI_SEL_O), 64'(e.sel));
                        check("grant_data",   64'(bus.SPI_DATA_O), 64'(e.data));
                        check("grant_star",   64'(bus.SPI_STAR_O), 64'd1);
                        check("grant_busy",   64'(bus.BUSY_O), 64'd1);
                    end
                end
                if (bus.SPI_STAR_O) star_cycles++;
                if (bus.ACK_O != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 64'(bus.ACK_O), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("ack_vec",   64'(bus.ACK_O), 64'(1 << e.idx));
                        check("ack_err",   64'(bus.ERR_O), 64'(e.err));
                        check("ack_rdata", 64'(bus.RDATA_O), 64'(e.rdata));
                        check("ack_data_held", 64'(bus.SPI_DATA_O), 64'(e.data));
                        check("ack_sel_held",  64'(bus.SPI_SEL_O), 64'(e.sel));
                        if (e.err) check("timeout_star_cycles", 64'(star_cycles), 64'(TIMEOUT));
                        if (hold_left > 0) begin
                            hold_left--;
                            if (hold_left == 0) bus.REQ_I = '0;
                        end else begin
                            bus.REQ_I[e.idx] = 1'b0;
                        end
                    end
                end
            end
            prev_grant = bus.GRANT_O;
        end
    end

    initial begin
        bus.REQ_I  = '0;
        bus.SEL_I  = '0;
        bus.DATA_I = '0;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Contention from reset: requester 0 first, strict rotation.
        bus.SEL_I  = {2'd2, 2'd1, 2'd0};
        bus.DATA_I = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        eng_rdata  = 32'h0BAD_F00D;
        hold_left  = 6;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) begin
                exp_t e;
                e.idx = i; e.sel = 2'(i); e.data = 32'hC0DE_0000 + 32'(i);
                e.rdata = 32'h0BAD_F00D; e.err = 1'b0;
                sb.push_back(e);
            end
        bus.REQ_I = 3'b111;
        drain("contention_drain", 2000);

        // Single request.
        eng_rdata = 32'h1111_2222;
        request(0, 2'd2, 32'h0000_00A5, 32'h1111_2222, 1'b0);
        drain("single_drain", 300);

        // Readback, then confirm the word is held.
        eng_rdata = 32'hDEAD_BEEF;
        request(0, 2'd1, 32'h1234_567E, 32'hDEAD_BEEF, 1'b0);
        drain("readback_drain", 300);
        eng_rdata = 32'h0;
        repeat (100) @(negedge clk);
        check("readback_hold", 64'(bus.RDATA_O), 64'hDEAD_BEEF);

        // Late request: requester 1 inputs change mid-transfer and must be ignored.
        eng_rdata = 32'h5555_AAAA;
        request(1, 2'd1, 32'hCAFE_0001, 32'h5555_AAAA, 1'b0);
        wait_grant("late_grant");
        repeat (5) @(negedge clk);
        bus.SEL_I[3:2]   = 2'd3;
        bus.DATA_I[63:32] = 32'hFFFF_0000;
        request(0, 2'd0, 32'hCAFE_0000, 32'h5555_AAAA, 1'b0);
        drain("late_drain", 600);

        // Timeout: RDATA_O unchanged, then a normal transfer.
        eng_mute  = 1'b1;
        eng_rdata = 32'h0102_0304;
        request(2, 2'd3, 32'h0000_7777, 32'h5555_AAAA, 1'b1);
        drain("timeout_drain", 500);
        eng_mute = 1'b0;
        request(2, 2'd3, 32'h0000_8888, 32'h0102_0304, 1'b0);
        drain("post_timeout_drain", 300);

        // Reset during RELEASE: no ACK, reset outputs, requester 0 wins afterwards.
        request(1, 2'd1, 32'h0000_ABCD, 32'h0102_0304, 1'b0);
        wait_grant("rstmid_grant");
        wait_star_low("rstmid_release");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.REQ_I = '0;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("rstmid");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_no_ack", 64'(bus.ACK_O), 64'd0);
        bus.SEL_I  = {2'd2, 2'd1, 2'd0};
        bus.DATA_I = {32'hBEE0_0002, 32'hBEE0_0001, 32'hBEE0_0000};
        eng_rdata  = 32'h4242_4242;
        hold_left  = 3;
        for (int i = 0; i < NREQ; i++) begin
            exp_t e;
            e.idx = i; e.sel = 2'(i); e.data = 32'hBEE0_0000 + 32'(i);
            e.rdata = 32'h4242_4242; e.err = 1'b0;
            sb.push_back(e);
        end
        bus.REQ_I = 3'b111;
        drain("rst_contention_drain", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
